// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS datapath.
// Contents:
//   REG_AW     - register address width
//   REG_ZERO   - architectural zero register address ($0)
//   fwd_sel_t  - EX-stage ALU operand select encoding
package pipe_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // 00: register file, 10: EX/MEM ALU result, 01: MEM/WB write data
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b01
  } fwd_sel_t;

endpackage

// File: rtl/forwarding_unit_chk.sv
// Simulation-only property checks on the forwarding unit's internal tags.
// Ports:
//   clk, rst_n     in  pipeline clock and synchronous active-low reset
//   mem_regwrite   in  MEM-stage RegWrite tag
//   mem_memread    in  MEM-stage MemRead tag
//   fwd_a, fwd_b   in  registered operand selects
module forwarding_unit_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       mem_regwrite,
  input logic       mem_memread,
  input logic [1:0] fwd_a,
  input logic [1:0] fwd_b
);

  // A load always writes its destination register.
  a_load_writes: assert property (@(posedge clk) disable iff (!rst_n)
    mem_memread |-> mem_regwrite);

  // 2'b11 is not a legal select.
  a_fwd_a_legal: assert property (@(posedge clk) disable iff (!rst_n)
    fwd_a != 2'b11);
  a_fwd_b_legal: assert property (@(posedge clk) disable iff (!rst_n)
    fwd_b != 2'b11);

endmodule

// File: rtl/fwd_sel_calc.sv
// Priority forwarding-select compare for one source operand.
// The result is the select the operand needs once the instruction
// currently in ID has advanced into EX.
// Ports:
//   bubble        in  ID instruction is being replaced by a NOP
//   src           in  source register address read by the ID instruction
//   ex_dest       in  destination tag of the instruction now in EX
//   ex_regwrite   in  EX instruction writes the register file
//   ex_memread    in  EX instruction is a load
//   mem_dest      in  destination tag of the instruction now in MEM
//   mem_regwrite  in  MEM instruction writes the register file
//   sel           out forwarding select for this operand
module fwd_sel_calc
  import pipe_pkg::*;
#(
  parameter int REG_AW   = pipe_pkg::REG_AW,
  parameter bit FWD_ZERO = 1'b0
) (
  input  logic              bubble,
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_regwrite,
  output fwd_sel_t          sel
);

  logic ex_nz_s;
  logic mem_nz_s;

  // $0 is hard-wired, so a write to it is not a real producer unless
  // the FWD_ZERO override is set.
  assign ex_nz_s  = FWD_ZERO | (ex_dest  != REG_AW'(REG_ZERO));
  assign mem_nz_s = FWD_ZERO | (mem_dest != REG_AW'(REG_ZERO));

  // First match wins: the nearest producer (EX) beats the older one (MEM).
  // A load in EX cannot supply data next cycle, so it is skipped here; the
  // hazard unit stalls and the load is picked up from MEM one cycle later.
  always_comb begin
    sel = FWD_REG;
    if (bubble) begin
      sel = FWD_REG;
    end else if (ex_regwrite && !ex_memread && ex_nz_s && (ex_dest == src)) begin
      sel = FWD_MEM;
    end else if (mem_regwrite && mem_nz_s && (mem_dest == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/forwarding_unit.sv
// RAW-hazard forwarding unit for the 5-stage MIPS pipeline.
// Keeps a shadow pipeline of destination/control tags (ID/EX, EX/MEM,
// MEM/WB), registers the EX operand selects one cycle ahead, and drives
// the combinational register-file write-through bypass for ID.
// Ports:
//   clk, rst_n       in  pipeline clock, synchronous active-low reset
//   id_rs, id_rt     in  source fields of the ID instruction
//   id_dest          in  destination after RegDst selection
//   id_regwrite      in  RegWrite of the ID instruction
//   id_memread       in  MemRead of the ID instruction
//   bubble           in  hazard-unit flush: NOP into ID/EX
//   fwd_a, fwd_b     out EX ALU operand selects (registered)
//   id_byp_a/b       out ID Rs/Rt read takes WB write data this cycle
//   ex_dest          out destination tag held in ID/EX
//   ex_memread       out MemRead tag held in ID/EX
module forwarding_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW   = pipe_pkg::REG_AW,
  parameter bit FWD_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              id_byp_a,
  output logic              id_byp_b,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_memread
);

  logic [REG_AW-1:0] ex_dest_r;
  logic              ex_regwrite_r;
  logic              ex_memread_r;
  logic [REG_AW-1:0] mem_dest_r;
  logic              mem_regwrite_r;
  logic              mem_memread_r;
  logic [REG_AW-1:0] wb_dest_r;
  logic              wb_regwrite_r;
  fwd_sel_t          fwd_a_r;
  fwd_sel_t          fwd_b_r;
  fwd_sel_t          fwd_a_s;
  fwd_sel_t          fwd_b_s;
  logic              wb_nz_s;

  fwd_sel_calc #(.REG_AW(REG_AW), .FWD_ZERO(FWD_ZERO)) u_calc_a (
    .bubble       (bubble),
    .src          (id_rs),
    .ex_dest      (ex_dest_r),
    .ex_regwrite  (ex_regwrite_r),
    .ex_memread   (ex_memread_r),
    .mem_dest     (mem_dest_r),
    .mem_regwrite (mem_regwrite_r),
    .sel          (fwd_a_s)
  );

  fwd_sel_calc #(.REG_AW(REG_AW), .FWD_ZERO(FWD_ZERO)) u_calc_b (
    .bubble       (bubble),
    .src          (id_rt),
    .ex_dest      (ex_dest_r),
    .ex_regwrite  (ex_regwrite_r),
    .ex_memread   (ex_memread_r),
    .mem_dest     (mem_dest_r),
    .mem_regwrite (mem_regwrite_r),
    .sel          (fwd_b_s)
  );

  // Shadow tag pipeline plus registered operand selects; reset beats bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_dest_r      <= '0;
      ex_regwrite_r  <= 1'b0;
      ex_memread_r   <= 1'b0;
      mem_dest_r     <= '0;
      mem_regwrite_r <= 1'b0;
      mem_memread_r  <= 1'b0;
      wb_dest_r      <= '0;
      wb_regwrite_r  <= 1'b0;
      fwd_a_r        <= FWD_REG;
      fwd_b_r        <= FWD_REG;
    end else begin
      mem_dest_r     <= ex_dest_r;
      mem_regwrite_r <= ex_regwrite_r;
      mem_memread_r  <= ex_memread_r;
      wb_dest_r      <= mem_dest_r;
      wb_regwrite_r  <= mem_regwrite_r;
      if (bubble) begin
        ex_dest_r     <= '0;
        ex_regwrite_r <= 1'b0;
        ex_memread_r  <= 1'b0;
      end else begin
        ex_dest_r     <= id_dest;
        ex_regwrite_r <= id_regwrite;
        ex_memread_r  <= id_memread;
      end
      fwd_a_r <= fwd_a_s;
      fwd_b_r <= fwd_b_s;
    end
  end

  // Write-through: WB writes the register file in the same cycle ID reads
  // it, so ID takes the WB data directly. Always guarded on $0.
  assign wb_nz_s  = (wb_dest_r != REG_AW'(REG_ZERO));
  assign id_byp_a = wb_regwrite_r & wb_nz_s & (wb_dest_r == id_rs);
  assign id_byp_b = wb_regwrite_r & wb_nz_s & (wb_dest_r == id_rt);

  assign fwd_a      = fwd_a_r;
  assign fwd_b      = fwd_b_r;
  assign ex_dest    = ex_dest_r;
  assign ex_memread = ex_memread_r;

  forwarding_unit_chk u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_regwrite (mem_regwrite_r),
    .mem_memread  (mem_memread_r),
    .fwd_a        (fwd_a_r),
    .fwd_b        (fwd_b_r)
  );

endmodule

// File: tb/tb_forwarding_unit.sv
// Scoreboard bench for forwarding_unit: each directed vector pushes its
// hand-computed expectations (tagged with the cycle they apply to) and a
// negedge monitor pops and compares them.
module tb_forwarding_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_dest;
  logic       id_regwrite;
  logic       id_memread;
  logic       bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       id_byp_a;
  logic       id_byp_b;
  logic [4:0] ex_dest;
  logic       ex_memread;

  forwarding_unit #(.REG_AW(5), .FWD_ZERO(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_dest     (id_dest),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .bubble      (bubble),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .id_byp_a    (id_byp_a),
    .id_byp_b    (id_byp_b),
    .ex_dest     (ex_dest),
    .ex_memread  (ex_memread)
  );

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   act;

  localparam int K_FA = 0, K_FB = 1, K_EXD = 2, K_EXM = 3, K_BA = 4, K_BB = 5;
  localparam int REG = 0, MEM = 2, WB = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int kind);
    case (kind)
      K_FA:    return int'(fwd_a);
      K_FB:    return int'(fwd_b);
      K_EXD:   return int'(ex_dest);
      K_EXM:   return int'(ex_memread);
      K_BA:    return int'(id_byp_a);
      K_BB:    return int'(id_byp_b);
      default: return -1;
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_FA:    return "fwd_a";
      K_FB:    return "fwd_b";
      K_EXD:   return "ex_dest";
      K_EXM:   return "ex_memread";
      K_BA:    return "id_byp_a";
      K_BB:    return "id_byp_b";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = actual(sb[i].kind);
        total = total + 1;
        if (act != sb[i].val) begin
          bad = bad + 1;
          $display("FAIL %s cyc=%0d got=%0d want=%0d", kname(sb[i].kind), cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  // Drive one ID cycle. Bypass expectations apply this cycle; select and
  // ID/EX tag expectations apply the next cycle.
  task automatic run(input bit rstv, input int rs, input int rt, input int dst,
                     input bit rw, input bit mr, input bit bub, input bit chk,
                     input int efa, input int efb, input int eba, input int ebb,
                     input int eexd, input int eexm);
    @(posedge clk);
    #1;
    rst_n       = rstv;
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_dest     = 5'(dst);
    id_regwrite = rw;
    id_memread  = mr;
    bubble      = bub;
    if (chk) begin
      sb.push_back('{cyc, K_BA, eba});
      sb.push_back('{cyc, K_BB, ebb});
    end
    sb.push_back('{cyc + 1, K_FA, efa});
    sb.push_back('{cyc + 1, K_FB, efb});
    sb.push_back('{cyc + 1, K_EXD, eexd});
    sb.push_back('{cyc + 1, K_EXM, eexm});
  endtask

  initial begin
    rst_n = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_dest = 5'd0;
    id_regwrite = 1'b0; id_memread = 1'b0; bubble = 1'b0;

    //  rst rs  rt  dst rw mr bb chk  fa   fb   ba bb exd exm
    run(0,  0,  0,  0, 0, 0, 0, 0,  REG, REG, 0, 0,  0, 0);  // reset
    run(0,  0,  0,  0, 0, 0, 1, 1,  REG, REG, 0, 0,  0, 0);  // reset + bubble
    run(1,  1,  2,  3, 1, 0, 0, 1,  REG, REG, 0, 0,  3, 0);  // add $3,$1,$2
    run(1,  3,  5,  4, 1, 0, 0, 1,  MEM, REG, 0, 0,  4, 0);  // sub $4,$3,$5
    run(1,  1,  2,  3, 1, 0, 0, 1,  REG, REG, 0, 0,  3, 0);  // add $3,$1,$2
    run(1, 12, 13, 11, 1, 0, 0, 1,  REG, REG, 0, 0, 11, 0);  // independent
    run(1,  7,  3,  6, 1, 0, 0, 1,  REG, WB,  0, 0,  6, 0);  // or $6,$7,$3
    run(1,  9,  8,  8, 1, 1, 0, 1,  REG, REG, 0, 0,  8, 1);  // lw $8,0($9)
    run(1,  8,  8, 10, 1, 0, 1, 1,  REG, REG, 0, 0,  0, 0);  // add stalled
    run(1,  8,  8, 10, 1, 0, 0, 1,  WB,  WB,  0, 0, 10, 0);  // add reissued
    run(1,  1,  2,  3, 1, 0, 0, 1,  REG, REG, 0, 0,  3, 0);  // $3 in MEM
    run(1,  1,  2,  3, 1, 0, 0, 1,  REG, REG, 0, 0,  3, 0);  // $3 in EX
    run(1,  3,  3,  4, 1, 0, 0, 1,  MEM, MEM, 0, 0,  4, 0);  // nearest wins
    run(1,  1,  2,  0, 1, 0, 0, 1,  REG, REG, 0, 0,  0, 0);  // write $0
    run(1,  0,  0,  7, 1, 0, 0, 1,  REG, REG, 0, 0,  7, 0);  // read $0 (EX)
    run(1,  0,  0,  0, 0, 0, 0, 1,  REG, REG, 0, 0,  0, 0);  // read $0 (MEM)
    run(1,  0,  0,  0, 0, 0, 0, 1,  REG, REG, 0, 0,  0, 0);  // read $0 (WB)
    run(1,  1,  2,  5, 1, 0, 0, 1,  REG, REG, 0, 0,  5, 0);  // add $5
    run(1,  0,  0,  0, 0, 0, 0, 1,  REG, REG, 0, 0,  0, 0);  // nop
    run(1,  0,  0,  0, 0, 0, 0, 1,  REG, REG, 0, 0,  0, 0);  // nop
    run(1,  5,  9, 12, 1, 0, 0, 1,  REG, REG, 1, 0, 12, 0);  // $5 in WB
    run(1,  9, 12, 13, 1, 0, 0, 1,  REG, MEM, 0, 0, 13, 0);  // rt from EX
    run(1,  1,  2, 14, 1, 0, 0, 1,  REG, REG, 0, 0, 14, 0);  // producer $14
    run(0, 14, 12, 15, 1, 0, 0, 1,  REG, REG, 0, 1,  0, 0);  // reset, $14 in EX
    run(1, 14, 14, 15, 1, 0, 0, 1,  REG, REG, 0, 0, 15, 0);  // post-reset use
    run(1, 14, 14,  0, 0, 0, 0, 1,  REG, REG, 0, 0,  0, 0);  // no stale WB

    @(posedge clk);
    @(negedge clk);
    #1;
    total = total + 1;
    if (fwd_a != 2'b00) begin
        bad = bad + 1;
        $display("FAIL final fwd_a got=%0d want=0", fwd_a);
    end
    total = total + 1;
    if (fwd_b != 2'b00) begin
        bad = bad + 1;
        $display("FAIL final fwd_b got=%0d want=0", fwd_b);
    end
    total = total + 1;
    if (ex_dest != 5'd0) begin
        bad = bad + 1;
        $display("FAIL final ex_dest got=%0d want=0", ex_dest);
    end
    total = total + 1;
    if (ex_memread != 1'b0) begin
        bad = bad + 1;
        $display("FAIL final ex_memread got=%0d want=0", ex_memread);
    end
    while (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL unchecked %s due=%0d want=%0d", kname(sb[0].kind), sb[0].cyc, sb[0].val);
      sb.delete(0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
